// File: rtl/cu_cmd_ctrl_if.sv
// Arbiter <-> CU command bus: request/address/data from the arbiter,
// read data, ack and busy back from the CU.
interface cu_cmd_ctrl_if #(
    parameter int AXI_WIDTH = 64
);
    logic [AXI_WIDTH-1:0] ar2cu_data_out;
    logic                 ar2cu_data_out_valid;
    logic [AXI_WIDTH-1:0] ar2cu_addr;
    logic                 ar2cu_addr_valid;
    logic                 ar2cu_wr_rqst;
    logic                 ar2cu_rd_rqst;
    logic [AXI_WIDTH-1:0] cu2ar_data_in;
    logic                 cu2ar_data_in_valid;
    logic                 cu2ar_ack;
    logic                 cu2ar_busy;

    modport master (
        output ar2cu_data_out, ar2cu_data_out_valid, ar2cu_addr, ar2cu_addr_valid,
               ar2cu_wr_rqst, ar2cu_rd_rqst,
        input  cu2ar_data_in, cu2ar_data_in_valid, cu2ar_ack, cu2ar_busy
    );

    modport slave (
        input  ar2cu_data_out, ar2cu_data_out_valid, ar2cu_addr, ar2cu_addr_valid,
               ar2cu_wr_rqst, ar2cu_rd_rqst,
        output cu2ar_data_in, cu2ar_data_in_valid, cu2ar_ack, cu2ar_busy
    );
endinterface

// File: rtl/cu_cmd_ctrl.sv
// CU command front end: captures arbiter requests, owns the CU register bank
// (CTRL / STATUS / config) and runs the workload start/done handshake.
module cu_cmd_ctrl #(
    parameter int AXI_WIDTH = 64,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_LSB  = 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    cu_cmd_ctrl_if.slave                  bus,
    output logic                          cu2ar_start_wl,
    input  logic                          wl_done,
    output logic [NUM_REGS*AXI_WIDTH-1:0] cfg_regs
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int HI_LSB = ADDR_LSB + IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_ACK} state_t;

    state_t               r_state, w_state_next;
    logic [AXI_WIDTH-1:0] r_addr, r_data, r_rd_data;
    logic                 r_addr_ok, r_data_ok, r_is_read;
    logic                 r_running, r_done, r_start_err, r_start_wl;

    logic                 w_addr_ok, w_data_ok, w_wr_go, w_rd_go;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_in_range, w_wr_en, w_sel_ctrl, w_sel_stat;
    logic                 w_done_evt, w_run_eff, w_start_req, w_start_ok, w_start_rej;
    logic                 w_clr_done, w_clr_err;
    logic [AXI_WIDTH-1:0] w_rd_val;
    logic [AXI_WIDTH-1:0] w_reg [NUM_REGS];
    logic                 w_unused_lsb;

    // This cycle's valids count toward the decision, so capture and accept can coincide
    always_comb begin
        w_addr_ok = bus.ar2cu_addr_valid | r_addr_ok;
        w_data_ok = bus.ar2cu_data_out_valid | r_data_ok;
        w_wr_go   = bus.ar2cu_wr_rqst & w_addr_ok & w_data_ok;
        w_rd_go   = bus.ar2cu_rd_rqst & w_addr_ok & ~w_wr_go;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_addr_ok <= 1'b0;
            r_data_ok <= 1'b0;
            r_is_read <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (bus.ar2cu_addr_valid) begin
                r_addr    <= bus.ar2cu_addr;
                r_addr_ok <= 1'b1;
            end
            if (bus.ar2cu_data_out_valid) begin
                r_data    <= bus.ar2cu_data_out;
                r_data_ok <= 1'b1;
            end
            if (w_wr_go || w_rd_go) begin
                r_is_read <= w_rd_go;
            end
        end else if (r_state == S_ACK) begin
            r_addr_ok <= 1'b0;
            r_data_ok <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr_go) begin
                    w_state_next = S_WRITE;
                end else if (w_rd_go) begin
                    w_state_next = S_READ;
                end
            end
            S_WRITE: w_state_next = S_ACK;
            S_READ:  w_state_next = S_ACK;
            S_ACK:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cu2ar_ack           = (r_state == S_ACK);
        bus.cu2ar_data_in_valid = (r_state == S_ACK) & r_is_read;
        bus.cu2ar_busy          = (r_state != S_IDLE);
    end

    // Any address bit above the index field means index >= NUM_REGS (NUM_REGS is a power of two)
    assign w_idx        = r_addr[ADDR_LSB +: IDX_W];
    assign w_in_range   = (r_addr[AXI_WIDTH-1:HI_LSB] == '0);
    assign w_unused_lsb = ^r_addr[ADDR_LSB-1:0];
    assign w_wr_en      = (r_state == S_WRITE) & w_in_range;
    assign w_sel_ctrl   = w_wr_en & (w_idx == IDX_W'(0));
    assign w_sel_stat   = w_wr_en & (w_idx == IDX_W'(1));

    // wl_done retires the running workload before a coincident START is judged
    assign w_done_evt  = wl_done & r_running;
    assign w_run_eff   = r_running & ~wl_done;
    assign w_start_req = w_sel_ctrl & r_data[0];
    assign w_start_ok  = w_start_req & ~w_run_eff;
    assign w_start_rej = w_start_req & w_run_eff;
    assign w_clr_done  = w_sel_stat & r_data[1];
    assign w_clr_err   = w_sel_stat & r_data[2];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            r_start_wl  <= 1'b0;
        end else begin
            r_running   <= w_start_ok | w_run_eff;
            r_done      <= (r_done & ~w_clr_done) | w_done_evt;
            r_start_err <= (r_start_err & ~w_clr_err) | w_start_rej;
            r_start_wl  <= w_start_ok;
        end
    end

    assign cu2ar_start_wl = r_start_wl;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_ctrl
                assign w_reg[gi] = '0;
            end else if (gi == 1) begin : g_status
                assign w_reg[gi] = {{(AXI_WIDTH-3){1'b0}}, r_start_err, r_done, r_running};
            end else begin : g_cfg
                logic [AXI_WIDTH-1:0] r_cfg;
                always_ff @(posedge clk) begin
                    if (!rstn) begin
                        r_cfg <= '0;
                    end else if (w_wr_en && (w_idx == IDX_W'(gi))) begin
                        r_cfg <= r_data;
                    end
                end
                assign w_reg[gi] = r_cfg;
            end
            assign cfg_regs[gi*AXI_WIDTH +: AXI_WIDTH] = w_reg[gi];
        end
    endgenerate

    assign w_rd_val = w_in_range ? w_reg[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_data <= '0;
        end else if (r_state == S_READ) begin
            r_rd_data <= w_rd_val;
        end
    end

    assign bus.cu2ar_data_in = r_rd_data;
endmodule

// File: doc/cu_cmd_ctrl.md
Name: cu_cmd_ctrl

Overview:
- Control-unit command front end. Sits directly downstream of the IFU/DFU arbiter and consumes its ar2cu_* request stream.
- Owns the CU register bank and decodes write and read requests against it.
- Returns ack, read data and busy to the arbiter.
- Launches and tracks a compute workload through a start/done handshake with the compute engine.

Parameters:
AXI_WIDTH, 64, data/address width of the arbiter interface
NUM_REGS, 16, number of 64-bit CU registers (index width IDX_W = clog2(NUM_REGS))
ADDR_LSB, 3, byte-to-word shift; register index = ar2cu_addr[ADDR_LSB +: IDX_W]

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
ar2cu_data_out  in  AXI_WIDTH  write data from arbiter
ar2cu_data_out_valid  in  1  write data valid
ar2cu_addr  in  AXI_WIDTH  byte address from arbiter
ar2cu_addr_valid  in  1  address valid
ar2cu_wr_rqst  in  1  write request
ar2cu_rd_rqst  in  1  read request
cu2ar_data_in  out  AXI_WIDTH  read data
cu2ar_data_in_valid  out  1  read data valid, 1-cycle pulse
cu2ar_ack  out  1  transaction complete, 1-cycle pulse
cu2ar_busy  out  1  transaction in progress
cu2ar_start_wl  out  1  workload start, 1-cycle pulse
wl_done  in  1  workload finished pulse from compute engine
cfg_regs  out  NUM_REGS*AXI_WIDTH  flat register bank; reg i at bits [i*AXI_WIDTH +: AXI_WIDTH]

Behaviour:
- Reset (rstn=0 at posedge): FSM=IDLE; all registers 0; capture flags cleared; every output 0.
- Register map:
  - reg0 CTRL: bit0 START, write-1, self-clearing, reads 0.
  - reg1 STATUS, read-only except W1C:
    - bit0 RUNNING.
    - bit1 DONE, sticky, W1C.
    - bit2 START_ERR, sticky, W1C.
    - All other bits read 0.
  - reg2..NUM_REGS-1: plain R/W config.
  - Index >= NUM_REGS: write ignored, read returns 0, ack still issued.
- Capture, IDLE only:
  - addr_valid latches addr and sets addr_ok.
  - data_valid latches data and sets data_ok.
  - Same-cycle valid and request are honoured, i.e. capture plus decision in one cycle.
  - A newer valid overwrites the latched value.
- FSM states: IDLE, WRITE, READ, ACK.
  - IDLE→WRITE: wr_rqst && addr_ok && data_ok (including this cycle's valids).
  - IDLE→READ: rd_rqst && addr_ok and no write qualifying.
  - wr_rqst and rd_rqst together: write wins, read dropped.
  - Request without its required valids: no transition, flags retained.
  - WRITE: register update this cycle → ACK.
  - READ: cu2ar_data_in <= selected register → ACK.
  - ACK: cu2ar_ack=1; cu2ar_data_in_valid=1 only for reads; capture flags cleared → IDLE.
- Latency, with request accepted in cycle N: WRITE/READ in N+1, ack (and read data valid) in N+2, next request accepted in N+3.
- cu2ar_busy = (state != IDLE). It is registered with the state, so it is high N+1..N+2. Requests are ignored outside IDLE.
- cu2ar_data_in holds its last read value after ACK; it is only meaningful while valid.
- START handling:
  - CTRL write with bit0=1 and RUNNING=0: cu2ar_start_wl pulses in the ACK cycle and RUNNING sets in the same cycle.
  - If RUNNING=1: no pulse, START_ERR sets.
- wl_done: clears RUNNING and sets DONE on the next edge, in any FSM state. wl_done with RUNNING=0 is ignored.
- Simultaneous wl_done and START evaluation in the same cycle: done applies first, then the start is accepted (pulse issued, RUNNING=1, DONE=1).
- STATUS W1C and a same-cycle hardware set: the set wins.
- Reset mid-transaction: FSM → IDLE; no ack or pulse is generated for the aborted request.

Test Plan:
1. addr=0x10, data=0xDEAD_BEEF with wr_rqst in the same cycle N → busy N+1..N+2; ack only at N+2; cfg_regs reg2=0xDEADBEEF.
2. Write reg5=0x1234, then addr 0x28 with rd_rqst → data_in=0x1234, data_in_valid and ack together 2 cycles later. Read addr 0x400 (index 128, out of range) → data 0, ack issued.
3. Write CTRL=1 → start_wl one pulse coinciding with ack; STATUS read=0x1. Write CTRL=1 again → no pulse; STATUS=0x5.
4. Pulse wl_done → STATUS=0x6. Write STATUS=0x6 → STATUS=0x0. Repeat with wl_done in the same cycle as the START ack → start pulse issued, STATUS=0x3.
5. wr_rqst and rd_rqst together, addr 0x18, data 0xAA → write performed (reg3=0xAA), no data_in_valid. Then addr_valid only in one cycle, wr_rqst with data_valid two cycles later → write lands in the latched address.
6. Deassert rstn during WRITE → no ack, FSM IDLE, all outputs 0, registers 0.
